uart_ctrl: RTL and testbench
============================

# uart_ctrl

CPU-facing register controller for the `uart` block. It sequences the receive read handshake (`rd_avail`/`rd_req`/`rd_rdy`) into a one-byte prefetch holding register. It buffers CPU transmit writes in a small FIFO and drains them into the transmit path one byte at a time, paced by `wr_busy`. It sits between the system bus decoder and the `uart` instance and raises a level interrupt.

## Interface

Parameters:
- `TX_AW`, default 4: TX FIFO address width.
- `TX_DEPTH`, default 16: TX FIFO entries; must equal 2**TX_AW.
- `BUSY_TO`, default 15: maximum cycles to wait for `tx_busy` to rise after a `tx_en` pulse.

Ports:
- `sys_clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: bus access strobe, one cycle per access.
- `we` in 1: 1 = write, 0 = read (qualified by `cs`).
- `addr` in 2: register select.
- `wdata` in 8: bus write data.
- `rdata` out 8: registered bus read data.
- `irq` out 1: level interrupt.
- `rx_avail` in 1: connects to `uart.rd_avail`.
- `rx_req` out 1: connects to `uart.rd_req`.
- `rx_rdy` in 1: connects to `uart.rd_rdy`.
- `rx_data` in 8: connects to `uart.rd_data`.
- `tx_data` out 8: connects to `uart.wr_data`.
- `tx_en` out 1: connects to `uart.wr_en`.
- `tx_busy` in 1: connects to `uart.wr_busy`.

## Operation

Register map:
- 0 DATA
  - Read: returns `rx_hold` if `rx_valid`, else 0x00. A read with `rx_valid`=1 clears `rx_valid`.
  - Write: pushes `wdata` into the TX FIFO. If the FIFO is full, the byte is dropped and `ovf` is set.
- 1 STATUS
  - Read: {3'b0, `tx_active`, `ovf`, `tx_empty`, `tx_full`, `rx_valid`}.
  - Write: bit3=1 clears `ovf` (write-1-to-clear); other bits are ignored.
- 2 IEN: read/write; bit0 = RX interrupt enable, bit1 = TX-empty interrupt enable; bits 7:2 read 0.
- 3: reads 0x00; writes are ignored.

`irq` = (IEN[0] & `rx_valid`) | (IEN[1] & `tx_empty` & ~`tx_active`), combinational from registers.

RX FSM:
- R_IDLE: if `rx_avail` & ~`rx_valid`, pulse `rx_req` for exactly one cycle and go to R_WAIT.
- R_WAIT: wait for `rx_rdy`=1. On it, `rx_hold` <= `rx_data`, `rx_valid` <= 1, go to R_FULL.
- R_FULL: when a DATA read clears `rx_valid`, go to R_IDLE.
- `rx_req` is never asserted outside R_IDLE→R_WAIT.

TX FIFO:
- TX_DEPTH entries, pointers of TX_AW bits that wrap, `count` of TX_AW+1 bits.
- `tx_full` = (count == TX_DEPTH); `tx_empty` = (count == 0).
- A push is accepted iff count < TX_DEPTH at the start of the cycle. A simultaneous push and pop leaves count unchanged. A push when full is dropped even if a pop happens in the same cycle.

TX FSM (`tx_active` = state != T_IDLE):
- T_IDLE: if ~`tx_empty` & ~`tx_busy`, drive `tx_data` <= FIFO head, pulse `tx_en` for one cycle, pop, go to T_START.
- T_START: on `tx_busy`=1 go to T_RUN. If BUSY_TO cycles elapse without it, go to T_IDLE (the byte counts as sent).
- T_RUN: on `tx_busy`=0 go to T_IDLE.

## Timing

- Reset values:
  - All outputs: `rdata`=0, `irq`=0, `rx_req`=0, `tx_en`=0, `tx_data`=0.
  - Internal state: `rx_valid`=0, `ovf`=0, IEN=0, FIFO empty, both FSMs idle.
- Reset assertion mid-transfer aborts immediately. Any byte in flight in `uart` is not tracked; after reset the RX FSM re-requests on `rx_avail`.
- Read latency: `rdata` is valid the cycle after the `cs`&~`we` cycle and holds until the next read.
- A DATA read that clears `rx_valid` frees R_FULL on the next edge. The next `rx_req` is issued no earlier than one cycle later.
- When a DATA read and the `rx_rdy` capture occur in the same cycle (R_WAIT), the read returns 0x00 and the new byte is latched with `rx_valid`=1.
- `rx_req` to capture: the controller waits on `rx_rdy` without a timeout. With `uart`, `rx_rdy` arrives 3 cycles after `rx_req`.
- Back-to-back TX: consecutive `tx_en` pulses are separated by at least one full `tx_busy` high period (or a BUSY_TO timeout), plus one T_IDLE cycle.
- A written byte can reach `tx_en` no earlier than the cycle after the write.

## Test plan

- Reset: hold `reset_n`=0 with random inputs → all outputs 0 and STATUS read = 0x04 after release.
- RX: `rx_avail`=1 and `rx_rdy` returned 3 cycles after `rx_req` with `rx_data`=0xA5 → one `rx_req` pulse; STATUS=0x05; DATA read → 0xA5; next STATUS bit0=0; a second DATA read → 0x00.
- RX backpressure: two bytes pending (0x11, 0x22), CPU does not read → exactly one `rx_req` until DATA is read; reads return 0x11 then 0x22 in order.
- TX drain: write 0x41, 0x42, 0x43 with a model `tx_busy` high for 20 cycles per byte → three `tx_en` pulses carrying 0x41, 0x42, 0x43 in order, none while `tx_busy`=1; STATUS bit2 returns to 1.
- TX overflow: hold `tx_busy`=1 and write 17 bytes → STATUS shows `tx_full`=1 and `ovf`=1; write STATUS 0x08 → `ovf`=0; the 16 bytes drain and the 17th is absent.
- IRQ and timeout: IEN=0x03 with an empty idle FIFO → `irq`=1; write one byte with `tx_busy` tied 0 → `irq` drops, FSM returns to T_IDLE after BUSY_TO cycles, `irq`=1 again.

Source files
------------

// File: rtl/uart_ctrl_if.sv
// Bus-side register port of uart_ctrl: one-cycle access strobes from the decoder,
// registered read data and a level interrupt back.
interface uart_ctrl_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  modport master (output cs, we, addr, wdata, input  rdata, irq);
  modport slave  (input  cs, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_ctrl.sv
// CPU register front-end for the uart block: one-byte RX prefetch, TX FIFO drained
// one byte per wr_busy cycle, and a level interrupt.
module uart_ctrl #(
  parameter int TX_AW    = 4,
  parameter int TX_DEPTH = 16,
  parameter int BUSY_TO  = 15
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  uart_ctrl_if.slave bus,
  input  logic       rx_avail,
  output logic       rx_req,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy
);

  localparam int              TO_W    = $clog2(BUSY_TO + 1);
  localparam logic [TX_AW:0]  DEPTH_C = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0]  CNT_ONE = (TX_AW + 1)'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    A_DATA   = 2'd0,
    A_STATUS = 2'd1,
    A_IEN    = 2'd2,
    A_RSVD   = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FULL} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_RUN} tx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  reg_addr_e addr_sel;
  logic      rd_acc;
  logic      wr_acc;
  logic      data_rd;
  logic      data_wr;

  assign addr_sel = reg_addr_e'(bus.addr);
  assign rd_acc   = bus.cs & ~bus.we;
  assign wr_acc   = bus.cs &  bus.we;
  assign data_rd  = rd_acc & (addr_sel == A_DATA);
  assign data_wr  = wr_acc & (addr_sel == A_DATA);

  // ---------------------------------------------------------------------------
  // RX prefetch FSM
  // ---------------------------------------------------------------------------
  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_hold_q,  rx_hold_d;
  logic       rx_req_q,   rx_req_d;
  logic       rx_valid;

  // The holding register is valid exactly while the FSM sits in R_FULL.
  assign rx_valid = (rx_state_q == R_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= R_IDLE;
      rx_hold_q  <= '0;
      rx_req_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_hold_q  <= rx_hold_d;
      rx_req_q   <= rx_req_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (rx_avail) rx_state_d = R_WAIT;
      R_WAIT:  if (rx_rdy)   rx_state_d = R_FULL;
      R_FULL:  if (data_rd)  rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_req_d  = (rx_state_q == R_IDLE) & rx_avail;
    rx_hold_d = rx_hold_q;
    if ((rx_state_q == R_WAIT) && rx_rdy) rx_hold_d = rx_data;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [TX_DEPTH];
  logic [TX_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [TX_AW:0]   count_q,  count_d;
  logic             tx_full;
  logic             tx_empty;
  logic             push;
  logic             pop;

  assign tx_full  = (count_q == DEPTH_C);
  assign tx_empty = (count_q == '0);
  assign push     = data_wr & ~tx_full;

  // NOTE: the storage array has no reset; count and pointers alone define
  // which entries are meaningful.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wdata;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + TX_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + TX_AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TX drain FSM
  // ---------------------------------------------------------------------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
  logic            tx_en_q,    tx_en_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            tx_active;

  assign tx_active = (tx_state_q != T_IDLE);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= T_IDLE;
      to_cnt_q   <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      to_cnt_q   <= to_cnt_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // A uart that never raises wr_busy must not wedge the queue, so T_START
  // gives up after BUSY_TO cycles and treats the byte as sent.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if (!tx_empty && !tx_busy) tx_state_d = T_START;
      T_START: begin
        if (tx_busy)                   tx_state_d = T_RUN;
        else if (to_cnt_q == TO_LAST)  tx_state_d = T_IDLE;
      end
      T_RUN:   if (!tx_busy) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    pop       = (tx_state_q == T_IDLE) & ~tx_empty & ~tx_busy;
    tx_en_d   = pop;
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    to_cnt_d  = (tx_state_q == T_START) ? to_cnt_q + TO_W'(1) : '0;
  end

  // ---------------------------------------------------------------------------
  // Control/status registers and read path
  // ---------------------------------------------------------------------------
  logic       ovf_q,   ovf_d;
  logic [1:0] ien_q,   ien_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (addr_sel)
      A_DATA:   rd_mux = rx_valid ? rx_hold_q : 8'h00;
      A_STATUS: rd_mux = {3'b000, tx_active, ovf_q, tx_empty, tx_full, rx_valid};
      A_IEN:    rd_mux = {6'b000000, ien_q};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    ovf_d   = ovf_q;
    ien_d   = ien_q;
    rdata_d = rdata_q;
    if (data_wr && tx_full) ovf_d = 1'b1;
    else if (wr_acc && (addr_sel == A_STATUS) && bus.wdata[3]) ovf_d = 1'b0;
    if (wr_acc && (addr_sel == A_IEN)) ien_d = bus.wdata[1:0];
    if (rd_acc) rdata_d = rd_mux;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      ien_q   <= '0;
      rdata_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      ien_q   <= ien_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = (ien_q[0] & rx_valid) | (ien_q[1] & tx_empty & ~tx_active);
  assign rx_req    = rx_req_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: behavioural uart models on the RX/TX side,
// queue scoreboards for bus reads and transmitted bytes, randomized traffic.
module tb_uart_ctrl;
  localparam int BUSY_TO = 15;
  localparam int DEPTH   = 16;

  typedef enum int {B_MODEL, B_FORCE, B_TIE0} busy_mode_e;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_avail = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       rx_req;
  logic       tx_en;
  logic [7:0] tx_data;

  uart_ctrl_if bus ();

  uart_ctrl #(.TX_AW(4), .TX_DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .rx_avail (rx_avail),
    .rx_req   (rx_req),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_busy  (tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: bytes the uart will hand over (in order), bytes the CPU
  // still expects to read, bytes expected on the transmit side.
  logic [7:0] src_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] rd_exp_q[$];

  bit         models_on = 1'b0;
  busy_mode_e busy_mode = B_MODEL;
  int         busy_len  = 20;
  int         busy_left = 0;
  int         req_cnt   = 0;
  int         tx_pulses = 0;
  int         rdy_cnt   = 0;
  logic [7:0] flight    = 8'h00;

  // uart receive side: hand over one byte 3 cycles after each rx_req.
  always @(negedge sys_clk) begin
    if (!models_on) begin
      rx_avail = 1'($urandom_range(0, 1));
      rx_rdy   = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      rdy_cnt  = 0;
    end else begin
      rx_rdy = 1'b0;
      if (rdy_cnt != 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) begin
          rx_rdy  = 1'b1;
          rx_data = flight;
        end
      end
      if (rx_req) begin
        req_cnt++;
        check("rx_req_has_byte", src_q.size() != 0, 1);
        if (src_q.size() != 0) flight = src_q.pop_front();
        rdy_cnt = 3;
      end
      rx_avail = (src_q.size() != 0);
    end
  end

  // uart transmit side plus transmit monitor.
  always @(negedge sys_clk) begin
    if (!models_on) begin
      tx_busy   = 1'($urandom_range(0, 1));
      busy_left = 0;
    end else begin
      if (tx_en) begin
        tx_pulses++;
        check("tx_en_while_busy", tx_busy, 0);
        check("tx_byte_expected", tx_exp_q.size() != 0, 1);
        if (tx_exp_q.size() != 0) check("tx_data", tx_data, tx_exp_q.pop_front());
      end
      case (busy_mode)
        B_FORCE: tx_busy = 1'b1;
        B_TIE0:  tx_busy = 1'b0;
        default: begin
          tx_busy = (busy_left != 0);
          if (busy_left != 0) busy_left--;
          if (tx_en) busy_left = busy_len;
        end
      endcase
    end
  end

  // Read monitor: rdata is compared the cycle after each read strobe.
  bit rd_seen = 1'b0;
  always @(posedge sys_clk) rd_seen = reset_n && bus.cs && !bus.we;

  always @(negedge sys_clk) begin
    if (rd_seen) begin
      check("rd_expected", rd_exp_q.size() != 0, 1);
      if (rd_exp_q.size() != 0) check(rd_name_q.pop_front(), bus.rdata, rd_exp_q.pop_front());
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge sys_clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    @(negedge sys_clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    rd_name_q.push_back(name);
    rd_exp_q.push_back(exp);
    @(negedge sys_clk);
    bus.cs = 1'b0;
  endtask

  // CPU sees the uart's bytes in order, and 0x00 when nothing is pending.
  task automatic read_data(input string name);
    logic [7:0] e;
    e = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'h00;
    bus_read(2'd0, e, name);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_exp_q.push_back(d);
    bus_write(2'd0, d);
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("tx_drain_done", tx_exp_q.size(), 0);
    repeat (BUSY_TO + 30) @(negedge sys_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         r0;
    int         p0;
    int         n;
    int         nrx;
    int         ntx;
    logic [7:0] b;
    logic [7:0] ien_v;

    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset with random inputs.
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      bus.cs    = 1'($urandom_range(0, 1));
      bus.we    = 1'($urandom_range(0, 1));
      bus.addr  = 2'($urandom);
      bus.wdata = 8'($urandom);
      #1;
      check("reset_outputs", {bus.rdata, bus.irq, rx_req, tx_en, tx_data}, 0);
    end
    @(negedge sys_clk);
    bus.cs = 1'b0; bus.we = 1'b0;
    models_on = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    bus_read(2'd1, 8'h04, "status_after_reset");
    bus_read(2'd2, 8'h00, "ien_after_reset");

    // RX single byte with RX interrupt enabled.
    bus_write(2'd2, 8'h01);
    r0 = req_cnt;
    src_q.push_back(8'hA5); rx_exp_q.push_back(8'hA5);
    repeat (10) @(negedge sys_clk);
    check("rx_req_single", req_cnt - r0, 1);
    check("irq_rx_valid", bus.irq, 1);
    bus_read(2'd1, 8'h05, "status_rx_valid");
    read_data("rx_data_a5");
    bus_read(2'd1, 8'h04, "status_rx_cleared");
    check("irq_rx_cleared", bus.irq, 0);
    read_data("rx_empty_read");
    bus_write(2'd2, 8'h00);

    // RX backpressure: second byte waits until the first is read.
    r0 = req_cnt;
    src_q.push_back(8'h11); rx_exp_q.push_back(8'h11);
    src_q.push_back(8'h22); rx_exp_q.push_back(8'h22);
    repeat (40) @(negedge sys_clk);
    check("rx_req_backpressure", req_cnt - r0, 1);
    read_data("rx_data_11");
    repeat (10) @(negedge sys_clk);
    check("rx_req_after_read", req_cnt - r0, 2);
    read_data("rx_data_22");
    repeat (10) @(negedge sys_clk);
    read_data("rx_drained_read");

    // DATA read in the same cycle as the rx_rdy capture returns 0x00.
    src_q.push_back(8'h5C); rx_exp_q.push_back(8'h5C);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!rx_req && n < 50);
    check("rx_req_seen", rx_req, 1);
    repeat (2) @(negedge sys_clk);
    bus_read(2'd0, 8'h00, "rx_read_during_capture");
    repeat (3) @(negedge sys_clk);
    bus_read(2'd1, 8'h05, "status_after_capture");
    read_data("rx_data_5c");

    // TX drain paced by a 20-cycle busy.
    busy_len = 20;
    p0 = tx_pulses;
    tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
    wait_tx_drain();
    check("tx_pulse_count", tx_pulses - p0, 3);
    bus_read(2'd1, 8'h04, "status_tx_drained");

    // TX overflow with the uart held busy.
    busy_mode = B_FORCE;
    repeat (3) @(negedge sys_clk);
    p0 = tx_pulses;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'h60 + 8'(i);
      if (i < DEPTH) tx_exp_q.push_back(b);
      bus_write(2'd0, b);
    end
    bus_read(2'd1, 8'h0A, "status_full_ovf");
    bus_write(2'd1, 8'hF7);
    bus_read(2'd1, 8'h0A, "status_ovf_kept");
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, 8'h02, "status_ovf_cleared");
    busy_len  = 2;
    busy_mode = B_MODEL;
    wait_tx_drain();
    check("tx_overflow_pulses", tx_pulses - p0, DEPTH);
    bus_read(2'd1, 8'h04, "status_after_overflow");

    // TX-empty interrupt and busy timeout.
    busy_mode = B_TIE0;
    bus_write(2'd2, 8'h03);
    check("irq_tx_empty_idle", bus.irq, 1);
    tx_write(8'h7E);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!tx_en && n < 20);
    check("tx_en_timeout_byte", tx_en, 1);
    n = 0;
    while (bus.irq == 1'b0 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    check("irq_low_cycles", n, BUSY_TO);
    check("irq_back_high", bus.irq, 1);
    bus_write(2'd2, 8'h00);
    busy_mode = B_MODEL;

    // Reserved address.
    bus_write(2'd3, 8'hFF);
    bus_read(2'd3, 8'h00, "rsvd_read");
    bus_read(2'd1, 8'h04, "status_after_rsvd_write");

    // Randomized mixed traffic.
    for (int it = 0; it < 8; it++) begin
      nrx      = $urandom_range(0, 2);
      ntx      = $urandom_range(0, 3);
      busy_len = $urandom_range(0, 8);
      ien_v    = 8'($urandom);
      bus_write(2'd2, ien_v);
      bus_read(2'd2, ien_v & 8'h03, "ien_readback");
      for (int k = 0; k < nrx; k++) begin
        b = 8'($urandom);
        src_q.push_back(b);
        rx_exp_q.push_back(b);
      end
      for (int k = 0; k < ntx; k++) tx_write(8'($urandom));
      repeat (12) @(negedge sys_clk);
      n = 0;
      while (rx_exp_q.size() != 0 && n < 4) begin
        read_data("rx_rand");
        repeat (12) @(negedge sys_clk);
        n++;
      end
      read_data("rx_rand_empty");
      wait_tx_drain();
      bus_read(2'd1, 8'h04, "status_rand_idle");
      check("irq_rand_idle", bus.irq, ien_v[1]);
    end
    bus_write(2'd2, 8'h00);

    repeat (4) @(negedge sys_clk);
    check("rd_scoreboard_empty", rd_exp_q.size(), 0);
    check("tx_scoreboard_empty", tx_exp_q.size(), 0);
    check("rx_source_empty", src_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
